// File: rtl/modular_op_sequencer.sv
// Round-robin sequencer for two requesters sharing a 4-bit modular add/sub datapath.
// Range-checks operands, holds the datapath inputs for SETTLE cycles, then returns the residue.
module modular_op_sequencer #(
    parameter logic [3:0] M      = 4'd13,
    parameter int         SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_sub,
    input  logic [3:0] req0_x,
    input  logic [3:0] req0_y,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_sub,
    input  logic [3:0] req1_x,
    input  logic [3:0] req1_y,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [3:0] resp_data,
    output logic       resp_err,
    output logic       dp_s,
    output logic [3:0] dp_x,
    output logic [3:0] dp_y,
    input  logic [3:0] dp_r,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    logic       ptr;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       acc_sub;
    logic [3:0] acc_x;
    logic [3:0] acc_y;
    logic       acc_err;

    // A lone valid requester wins outright; on contention the pointer decides.
    assign grant0 = req0_valid & (~req1_valid | ~ptr);
    assign grant1 = req1_valid & (~req0_valid | ptr);

    // Ready is forced low while reset is held, even though the state already reads IDLE.
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;

    assign acc_sub = grant1 ? req1_sub : req0_sub;
    assign acc_x   = grant1 ? req1_x   : req0_x;
    assign acc_y   = grant1 ? req1_y   : req0_y;
    assign acc_err = (acc_x >= M) | (acc_y >= M);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= 4'd0;
            resp_err   <= 1'b0;
            dp_s       <= 1'b0;
            dp_x       <= 4'd0;
            dp_y       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        resp_id <= grant1;
                        ptr     <= ~grant1;
                        // Out-of-range operands skip the datapath entirely and leave dp_* untouched.
                        if (acc_err) begin
                            resp_err   <= 1'b1;
                            resp_data  <= 4'd0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            dp_s  <= acc_sub;
                            dp_x  <= acc_x;
                            dp_y  <= acc_y;
                            cnt   <= CNT_INIT;
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_data  <= dp_r;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modular_op_sequencer.sv
// Directed bench for modular_op_sequencer: one instance with SETTLE=1, one with SETTLE=3,
// each driven by a behavioural mod-13 datapath.
module tb_modular_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_sub, req1_valid, req1_sub;
    logic [3:0] req0_x, req0_y, req1_x, req1_y;
    logic       req0_ready, req1_ready;
    logic       resp_valid, resp_ready, resp_id, resp_err;
    logic [3:0] resp_data;
    logic       dp_s;
    logic [3:0] dp_x, dp_y, dp_r;
    logic       busy;

    logic       r3_req0_valid, r3_req0_sub, r3_req1_valid, r3_req1_sub;
    logic [3:0] r3_req0_x, r3_req0_y, r3_req1_x, r3_req1_y;
    logic       r3_req0_ready, r3_req1_ready;
    logic       r3_resp_valid, r3_resp_ready, r3_resp_id, r3_resp_err;
    logic [3:0] r3_resp_data;
    logic       r3_dp_s;
    logic [3:0] r3_dp_x, r3_dp_y, r3_dp_r;
    logic       r3_busy;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] arb_data [4];
    logic       arb_id   [4];

    always #5 clk = ~clk;

    // Reference modulo-13 datapath, valid for in-range operands.
    function automatic logic [3:0] dp_model(input logic s, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] t;
        if (!s) begin
            t = {1'b0, x} + {1'b0, y};
            if (t >= 5'd13) t = t - 5'd13;
        end else if (x >= y) begin
            t = {1'b0, x} - {1'b0, y};
        end else begin
            t = {1'b0, x} + 5'd13 - {1'b0, y};
        end
        return t[3:0];
    endfunction

    assign dp_r    = dp_model(dp_s, dp_x, dp_y);
    assign r3_dp_r = dp_model(r3_dp_s, r3_dp_x, r3_dp_y);

    modular_op_sequencer #(.M(4'd13), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
        .req1_x(req1_x), .req1_y(req1_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .dp_s(dp_s), .dp_x(dp_x), .dp_y(dp_y), .dp_r(dp_r), .busy(busy)
    );

    modular_op_sequencer #(.M(4'd13), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r3_req0_valid), .req0_ready(r3_req0_ready), .req0_sub(r3_req0_sub),
        .req0_x(r3_req0_x), .req0_y(r3_req0_y),
        .req1_valid(r3_req1_valid), .req1_ready(r3_req1_ready), .req1_sub(r3_req1_sub),
        .req1_x(r3_req1_x), .req1_y(r3_req1_y),
        .resp_valid(r3_resp_valid), .resp_ready(r3_resp_ready), .resp_id(r3_resp_id),
        .resp_data(r3_resp_data), .resp_err(r3_resp_err),
        .dp_s(r3_dp_s), .dp_x(r3_dp_x), .dp_y(r3_dp_y), .dp_r(r3_dp_r), .busy(r3_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic which, input logic v, input logic s,
                                 input logic [3:0] x, input logic [3:0] y);
        if (!which) begin
            req0_valid = v; req0_sub = s; req0_x = x; req0_y = y;
        end else begin
            req1_valid = v; req1_sub = s; req1_x = x; req1_y = y;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cycles;
        arb_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
        arb_data = '{4'd10, 4'd8, 4'd11, 4'd1};

        rst_n = 1'b0;
        resp_ready = 1'b1;
        r3_resp_ready = 1'b1;
        r3_req0_valid = 1'b0; r3_req0_sub = 1'b0; r3_req0_x = 4'd0; r3_req0_y = 4'd0;
        r3_req1_valid = 1'b0; r3_req1_sub = 1'b0; r3_req1_x = 4'd0; r3_req1_y = 4'd0;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd9, 4'd7);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 4'd1);

        $display("[TB] reset with both requesters valid");
        tick(); tick();
        checkOutput("rst_ready0", {7'd0, req0_ready}, 8'd0);
        checkOutput("rst_ready1", {7'd0, req1_ready}, 8'd0);
        checkOutput("rst_resp_valid", {7'd0, resp_valid}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("rst_dp", {dp_s, dp_x, dp_y[2:0]}, 8'd0);
        checkOutput("rst_dp_y3", {7'd0, dp_y[3]}, 8'd0);
        checkOutput("rst_resp", {2'd0, resp_id, resp_err, resp_data}, 8'd0);

        rst_n = 1'b1;
        #1;
        checkOutput("first_grant0", {7'd0, req0_ready}, 8'd1);
        checkOutput("first_grant1", {7'd0, req1_ready}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("[TB] add 9+7 from requester 0");
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("add_dp_x", {4'd0, dp_x}, 8'd9);
        checkOutput("add_dp_y", {4'd0, dp_y}, 8'd7);
        checkOutput("add_dp_s", {7'd0, dp_s}, 8'd0);
        checkOutput("add_busy", {7'd0, busy}, 8'd1);
        checkOutput("add_early_valid", {7'd0, resp_valid}, 8'd0);
        tick();
        checkOutput("add_valid", {7'd0, resp_valid}, 8'd1);
        checkOutput("add_data", {4'd0, resp_data}, 8'd3);
        checkOutput("add_id", {7'd0, resp_id}, 8'd0);
        checkOutput("add_err", {7'd0, resp_err}, 8'd0);
        tick();

        $display("[TB] range check x=13 from requester 1");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd13, 4'd1);
        #1;
        checkOutput("range_ready1", {7'd0, req1_ready}, 8'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("range_valid", {7'd0, resp_valid}, 8'd1);
        checkOutput("range_err", {7'd0, resp_err}, 8'd1);
        checkOutput("range_data", {4'd0, resp_data}, 8'd0);
        checkOutput("range_id", {7'd0, resp_id}, 8'd1);
        checkOutput("range_dp_hold", {dp_s, dp_x, dp_y[2:0]}, {1'b0, 4'd9, 3'd7});
        tick();
        checkOutput("range_idle_valid", {7'd0, resp_valid}, 8'd0);
        checkOutput("range_idle_busy", {7'd0, busy}, 8'd0);

        $display("[TB] arbitration with both requesters valid");
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd4, 4'd6);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 4'd8);
        for (int i = 0; i < 4; i++) begin
            cycles = 0;
            while (!resp_valid && cycles < 10) begin
                tick();
                cycles++;
            end
            checkOutput($sformatf("arb%0d_valid", i), {7'd0, resp_valid}, 8'd1);
            checkOutput($sformatf("arb%0d_id", i), {7'd0, resp_id}, {7'd0, arb_id[i]});
            checkOutput($sformatf("arb%0d_data", i), {4'd0, resp_data}, {4'd0, arb_data[i]});
            if (i == 1) applyStimulus(1'b0, 1'b1, 1'b0, 4'd12, 4'd12);
            if (i == 2) applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 4'd12);
            if (i == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
                applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
            end
            tick();
        end

        $display("[TB] backpressure then reset mid-execution");
        resp_ready = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 4'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 4'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d_valid", i), {7'd0, resp_valid}, 8'd1);
            checkOutput($sformatf("bp%0d_resp", i), {2'd0, resp_id, resp_err, resp_data}, 8'd5);
            checkOutput($sformatf("bp%0d_ready1", i), {7'd0, req1_ready}, 8'd0);
            if (i < 4) tick();
        end
        resp_ready = 1'b1;
        tick();
        checkOutput("bp_release_ready1", {7'd0, req1_ready}, 8'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("mid_busy", {7'd0, busy}, 8'd1);
        checkOutput("mid_dp_x", {4'd0, dp_x}, 8'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {7'd0, busy}, 8'd0);
        checkOutput("midrst_valid", {7'd0, resp_valid}, 8'd0);
        checkOutput("midrst_dp", {dp_s, dp_x, dp_y[2:0]}, 8'd0);
        checkOutput("midrst_dp_y3", {7'd0, dp_y[3]}, 8'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("postrst%0d_valid", i), {7'd0, resp_valid}, 8'd0);
        end

        $display("[TB] subtract 2-5 with SETTLE=3 from requester 1");
        r3_req1_valid = 1'b1; r3_req1_sub = 1'b1; r3_req1_x = 4'd2; r3_req1_y = 4'd5;
        #1;
        checkOutput("s3_ready1", {7'd0, r3_req1_ready}, 8'd1);
        tick();
        r3_req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("s3_hold%0d_dp", i), {r3_dp_s, r3_dp_x, r3_dp_y[2:0]}, {1'b1, 4'd2, 3'd5});
            checkOutput($sformatf("s3_hold%0d_valid", i), {7'd0, r3_resp_valid}, 8'd0);
            tick();
        end
        checkOutput("s3_valid", {7'd0, r3_resp_valid}, 8'd1);
        checkOutput("s3_data", {4'd0, r3_resp_data}, 8'd10);
        checkOutput("s3_id", {7'd0, r3_resp_id}, 8'd1);
        checkOutput("s3_err", {7'd0, r3_resp_err}, 8'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
